// File: rtl/priority_decoder_seq.sv
// Sequenced one-hot decoder: buffers binary codes in a small FIFO and replays
// each one as a one-hot strobe held for HOLD cycles. Code n drives bit n, so
// out_onehot[0] corresponds to code 0 (same bit numbering as the encoder).
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | nothing being driven; outputs zero; waiting for a FIFO entry
// DRIVE  | a code is on the outputs; hold counter runs down to zero
module priority_decoder_seq #(
  parameter int CODE_W = 2,
  parameter int DEPTH  = 4,
  parameter int HOLD   = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [CODE_W-1:0]      in_code,
  output logic                   in_ready,
  output logic [0:(2**CODE_W)-1] out_onehot,
  output logic                   out_valid,
  output logic [CODE_W-1:0]      out_code,
  output logic                   out_last
);

  localparam int OUT_W  = 2**CODE_W;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int HCNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;

  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
  localparam logic [HCNT_W-1:0] HOLD_LD  = HCNT_W'(HOLD - 1);

  typedef enum logic {
    ST_IDLE,
    ST_DRIVE
  } state_t;

  state_t              state_q, state_d;
  logic [HCNT_W-1:0]   hold_q, hold_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic [0:OUT_W-1]    onehot_q, onehot_d;

  logic [CODE_W-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic                push;
  logic                pop;

  // Ready depends only on the registered count, so a full FIFO refuses a
  // push even on an edge where it is also popping.
  assign in_ready = rst_n && (count_q != FULL_CNT);
  assign push     = in_valid && in_ready;

  // Next-state and output decode; loading a new code reloads the hold window.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    code_d   = code_q;
    valid_d  = valid_q;
    pop      = 1'b0;
    onehot_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          code_d  = mem_q[rd_ptr_q];
          valid_d = 1'b1;
          hold_d  = HOLD_LD;
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (hold_q != '0) begin
          hold_d = hold_q - 1'b1;
        end else if (count_q != '0) begin
          pop     = 1'b1;
          code_d  = mem_q[rd_ptr_q];
          valid_d = 1'b1;
          hold_d  = HOLD_LD;
        end else begin
          code_d  = '0;
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        code_d  = '0;
        valid_d = 1'b0;
        hold_d  = '0;
        state_d = ST_IDLE;
      end
    endcase
    last_d = (state_d == ST_DRIVE) && (hold_d == '0);
    if (valid_d) begin
      onehot_d[code_d] = 1'b1;
    end
  end

  // FIFO pointer and occupancy bookkeeping.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_code;
    end
  end

  // State, counters and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      hold_q   <= '0;
      code_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      onehot_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      onehot_q <= onehot_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign out_onehot = onehot_q;
  assign out_valid  = valid_q;
  assign out_code   = code_q;
  assign out_last   = last_q;

endmodule

// File: doc/priority_decoder_seq.md
Name: priority_decoder_seq

Overview:
- Sequenced decoder, the companion of the team's 4-input priority encoder.
- Accepts a stream of binary codes through a valid/ready handshake and buffers them in a small FIFO.
- Replays each code as a one-hot vector held for a fixed number of cycles. Code n drives bit n, matching the encoder's ascending bit numbering where bit 0 maps to code 00.
- Sits between arbitration/priority logic and request lines that need a stretched one-hot strobe.

Parameters:
- CODE_W, 2, code width in bits; OUT_W = 2**CODE_W (derived, not overridable).
- DEPTH, 4, FIFO entries; power of two, at least 2.
- HOLD, 3, cycles each one-hot output is held; at least 1.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  in_code is valid this cycle.
- in_code  input  CODE_W  code to decode; all values legal.
- in_ready  output  1  FIFO can accept; equals (count != DEPTH) and not in reset.
- out_onehot  output  [0:OUT_W-1]  one-hot decode; bit in_code set; all zero when idle.
- out_valid  output  1  out_onehot and out_code are driving a code.
- out_code  output  CODE_W  binary code currently being driven; 0 when idle.
- out_last  output  1  high on the final cycle of each hold window.

Behaviour:
- Reset (rst_n low at a rising edge):
  - FIFO pointers and count go to 0; FSM goes to IDLE; hold counter goes to 0.
  - out_onehot = 0, out_valid = 0, out_code = 0, out_last = 0.
  - in_ready is forced low while rst_n is low.
  - Reset mid-hold or with a non-empty FIFO discards everything; no output glitch after release.
- Accept: a push happens at an edge where in_valid & in_ready. in_ready comes from the registered count only, so a push is refused when full even if a pop occurs on the same edge.
- FIFO: write and read pointers wrap modulo DEPTH. Count changes +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- FSM states IDLE, DRIVE.
  - IDLE: if count > 0 at the edge, pop the head, load out_code, set out_onehot bit code, set out_valid = 1, hold counter = HOLD-1, go to DRIVE. Otherwise stay IDLE with outputs zero.
  - DRIVE: out_last = (hold counter == 0). While counter > 0, decrement and hold the outputs.
  - DRIVE, counter == 0 and count > 0: pop the next code and reload in the same edge (back-to-back windows, no idle gap), stay in DRIVE.
  - DRIVE, counter == 0 and count == 0: clear outputs, go to IDLE.
- Latency: a code accepted at edge k (FIFO empty, FSM IDLE) appears on the outputs after edge k+1. There is no same-edge bypass from in_code to the outputs.
- Window length: each code is driven for exactly HOLD cycles. out_last is high only on the last of them. With HOLD = 1, out_last equals out_valid.
- Empty FIFO during IDLE: no pop, no counter activity.
- A push on the same edge as a pop that empties the FIFO is legal; that entry is popped at the next eligible edge.
- Invariants: out_onehot has exactly one bit set when out_valid = 1, and is zero otherwise. out_onehot equals the decode of out_code at all times.
- All outputs are registered except in_ready, which is combinational from the registered count and rst_n.

Test Plan:
- Reset then single code: rst_n low 2 cycles; push in_code = 2'b10 at edge 3 → outputs from edge 4: out_onehot = 4'b0010 (bit 2), out_code = 2, out_valid high 3 cycles, out_last on the 3rd, then all zero.
- Back-to-back: push 0, 1, 3 on consecutive edges → out_onehot 1000 ×3, 0100 ×3, 0001 ×3 with no gap, then idle; out_last every 3rd cycle.
- Full FIFO: hold in_valid high with codes 0, 1, 2, 3, 0, 1 from idle → exactly DEPTH + 1 = 5 accepted (one popped immediately), in_ready low while count = 4. The 6th code is held until a pop, and no code is lost or duplicated in output order.
- Simultaneous push/pop at full: count = 4, pop edge coincides with in_valid → push refused that edge, accepted the next; count sequence 4, 3, 4.
- Reset mid-operation: 3 codes queued, mid-hold of the first, rst_n low 1 cycle → the following cycle shows all outputs 0, in_ready high, and no stale code emerges.
- HOLD = 1 build: push codes 3, 2 → out_onehot 0001 then 0010 for one cycle each; out_last = out_valid throughout.
